uart_char_tx: RTL
=================

UART_CHAR_TX -- requirements
Module: uart_char_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, clocks per serial bit period; legal range 2..4095.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, character buffer entries; fixed at 4 (2-bit pointers).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_data  input  8  ASCII character from the upstream message sequencer.
REQ-006 SHALL have port in_valid  input  1  in_data holds a character to transfer.
REQ-007 SHALL have port in_ready  output  1  block can accept a character this cycle.
REQ-008 SHALL have port tx  output  1  serial line, 8N1, idle high.
REQ-009 SHALL have port busy  output  1  a frame is in progress or the FIFO is non-empty.
REQ-010 SHALL have port fifo_count  output  3  current FIFO occupancy, 0..4.

Function
REQ-011 SHALL accept a character on any rising edge where in_valid=1 and in_ready=1; no other condition writes the FIFO.
REQ-012 SHALL drive in_ready = (fifo_count != 4) combinationally; in_ready SHALL NOT depend on in_valid.
REQ-013 SHALL deassert in_ready when full, even if a pop occurs in the same cycle; no push on full.
REQ-014 SHALL keep FIFO order first-in-first-out; pointers wrap 3->0; count increments on push-only, decrements on pop-only, and is unchanged on simultaneous push and pop.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 In IDLE: tx=1; if fifo_count!=0, pop head into an 8-bit shift register, clear the baud counter, and go to START.
REQ-017 In START: tx=0 for exactly CLKS_PER_BIT clocks, then go to DATA with bit index 0.
REQ-018 In DATA: tx=shift[0] (LSB first) for CLKS_PER_BIT clocks per bit; shift right after each bit; after bit 7 go to STOP.
REQ-019 In STOP: tx=1 for CLKS_PER_BIT clocks, then go to IDLE.
REQ-020 SHALL register tx (no combinational path from state to pin).
REQ-021 Latency: a character accepted into an empty FIFO at edge k with FSM in IDLE SHALL make tx fall at edge k+1.
REQ-022 Frame length SHALL be exactly 10*CLKS_PER_BIT clocks; back-to-back frames SHALL have exactly one idle-high clock between the stop bit and the next start bit.
REQ-023 The baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary.
REQ-024 busy SHALL be 1 when state!=IDLE or fifo_count!=0, else 0.
REQ-025 Bit value 0x80 and above SHALL transmit unmodified (no parity, no masking).
REQ-026 Pushes during an active frame SHALL buffer without disturbing tx timing.

Reset
REQ-027 While rst_n=1: state=IDLE, tx=1, fifo_count=0, pointers=0, baud counter=0, bit index=0, in_ready=1, busy=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately (tx=1 asynchronously) and discard the FIFO contents.
REQ-029 After rst_n falls, the first character SHALL be accepted on the first clock edge with in_valid=1.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration (2-bit encoding) and constants FRAME_BITS=10, DATA_BITS=8.
REQ-031 The FIFO SHALL be a separate sub-module char_fifo (4x8, synchronous, full/empty/count outputs, async active-high reset).
REQ-032 uart_char_tx SHALL contain the FSM, baud counter, bit index and shift register.

Verification (CLKS_PER_BIT=4)
REQ-033 Push 0x41 once -> tx low at the next edge; 4-clock bits 0,1,0,0,0,0,0,1,0,1; busy=0 after 40 clocks.
REQ-034 Hold in_valid=1 with 0x50,0x72,0x6F,0x79,0x65,0x63 -> in_ready drops after the 5th accept (4 queued + 1 in flight); all 6 frames serialize in order, each with one idle clock between frames.
REQ-035 Fill FIFO (count=4), hold in_valid with a 5th byte during the cycle the FSM pops -> byte not accepted that cycle; accepted the next cycle; count returns to 4.
REQ-036 Assert rst_n during the DATA bit 3 of 0xA1 with 2 bytes queued -> tx=1 immediately, count=0, no further frames.
REQ-037 Push 0xE1 -> bits 1,0,0,0,0,1,1,1 LSB first; stop bit high.
REQ-038 Random valid/pause over 200 characters -> a bench UART receiver recovers the identical sequence; fifo_count never exceeds 4.

Source files
------------

// File: rtl/uart_char_tx_pkg.sv
// Shared definitions for the character UART transmitter: FSM state encoding
// and frame geometry constants.
package uart_char_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned DATA_BITS  = 8;

    // Clocks occupied by one start+data+stop frame at a given bit period.
    function automatic int unsigned frame_clks(input int unsigned clks_per_bit);
        return FRAME_BITS * clks_per_bit;
    endfunction

endpackage

// File: rtl/char_fifo.sv
// 4-entry x 8-bit synchronous character FIFO with occupancy count.
// Pushes on full and pops on empty are ignored.
module char_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [2:0] count_o
);

    logic [7:0] mem_q [DEPTH];
    logic [1:0] wr_ptr_q;
    logic [1:0] rd_ptr_q;
    logic [2:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign full_o  = (count_q == 3'(DEPTH));
    assign empty_o = (count_q == 3'd0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; only occupied entries are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_char_tx.sv
// Buffered 8N1 serial transmitter: characters queue in a 4-deep FIFO and are
// shifted out LSB first, one CLKS_PER_BIT period per bit.
module uart_char_tx
    import uart_char_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic [2:0] fifo_count
);

    localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;

    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       pop;
    logic       baud_done;

    assign in_ready  = !fifo_full;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign tx        = tx_q;
    assign baud_done = (cnt_q == CNT_LAST);

    char_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid && in_ready),
        .wdata_i (in_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // tx_d is the line level for the state being entered, so the pin is a
    // flop and the start bit appears on the same edge as the pop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_done) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                tx_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule
